// File: rtl/psum_accum_pad.sv
// psum_accum_pad: partial-sum accumulation pad for a PE.
// A product is accepted into a one-deep stage register, summed into the
// addressed pad entry on the following edge and, when it closes an
// accumulation, the sum is pushed into a 2-entry result FIFO.
// Optional build macro: PSUM_SAT_EN -- saturating arithmetic plus a sticky
// o_sat flag. Without it, sums wrap modulo 2^DW and o_sat is absent.
module psum_accum_pad #(
    parameter int DEPTH = 16,
    parameter int PW    = 16,
    parameter int DW    = 20,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          Prod_rdy,
    output logic          Prod_ack,
    input  logic [PW-1:0] i_prod,
    input  logic [AW-1:0] i_paddr,
    input  logic          i_first,
    input  logic          i_last,
    output logic          Psum_rdy,
    input  logic          Psum_ack,
    output logic [DW-1:0] o_psum,
    output logic [AW-1:0] o_paddr,
    output logic          o_busy
`ifdef PSUM_SAT_EN
    ,
    output logic          o_sat
`endif
);

`ifdef PSUM_SAT_EN
    localparam logic [DW-1:0] SUM_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SUM_MIN = {1'b1, {(DW-1){1'b0}}};
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 s1_valid_q, s1_valid_d;
    logic [AW-1:0]        s1_addr_q,  s1_addr_d;
    logic signed [PW-1:0] s1_prod_q,  s1_prod_d;
    logic                 s1_first_q, s1_first_d;
    logic                 s1_last_q,  s1_last_d;

    logic [DW-1:0]        pad_q [DEPTH];
    logic [DW-1:0]        pad_d [DEPTH];

    logic [DW-1:0]        fifo_psum_q [2];
    logic [DW-1:0]        fifo_psum_d [2];
    logic [AW-1:0]        fifo_addr_q [2];
    logic [AW-1:0]        fifo_addr_d [2];
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           fifo_cnt_q, fifo_cnt_d;

    // ------------------------------------------------------------------
    // Handshake and datapath nets
    // ------------------------------------------------------------------
    logic                 pend_s;
    logic [1:0]           occ_s;
    logic                 prod_fire_s;
    logic                 push_s;
    logic                 pop_s;
    logic [DW-1:0]        pad_rd_s;
    logic signed [DW-1:0] base_s;
    logic signed [DW-1:0] prod_ext_s;
    logic signed [DW-1:0] sum_wrap_s;
    logic signed [DW-1:0] sum_s;
`ifdef PSUM_SAT_EN
    logic                 ovf_s;
    logic                 sat_q, sat_d;
`endif

    // A result still sitting in stage 1 already owns a FIFO slot, so the
    // acceptance check counts it. Only registered state feeds this, which
    // keeps Prod_ack free of any path from Prod_rdy. The i_rst term holds
    // the acknowledge low for the whole reset assertion.
    assign pend_s      = s1_valid_q & s1_last_q;
    assign occ_s       = fifo_cnt_q + {1'b0, pend_s};
    assign Prod_ack    = i_rst & ~i_clr & (occ_s < 2'd2);
    assign prod_fire_s = Prod_rdy & Prod_ack;

    assign push_s      = s1_valid_q & s1_last_q;
    assign pop_s       = (fifo_cnt_q != 2'd0) & Psum_ack;

    assign Psum_rdy    = (fifo_cnt_q != 2'd0);
    assign o_psum      = fifo_psum_q[rd_ptr_q];
    assign o_paddr     = fifo_addr_q[rd_ptr_q];
    assign o_busy      = s1_valid_q | (fifo_cnt_q != 2'd0);

    // Stage-1 capture: load on an accepted product, otherwise empty out
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        s1_prod_d  = s1_prod_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        if (i_clr) begin
            s1_valid_d = 1'b0;
            s1_addr_d  = {AW{1'b0}};
            s1_prod_d  = {PW{1'b0}};
            s1_first_d = 1'b0;
            s1_last_d  = 1'b0;
        end else if (prod_fire_s) begin
            s1_valid_d = 1'b1;
            s1_addr_d  = i_paddr;
            s1_prod_d  = i_prod;
            s1_first_d = i_first;
            s1_last_d  = i_last;
        end else begin
            s1_valid_d = 1'b0;
        end
    end

    // Accumulate: read the addressed entry (0 when out of range), add the
    // sign-extended product, optionally clamp on signed overflow
    always_comb begin
        pad_rd_s = {DW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (s1_addr_q == AW'(i)) begin
                pad_rd_s = pad_q[i];
            end else begin
                pad_rd_s = pad_rd_s;
            end
        end
        if (s1_first_q) begin
            base_s = {DW{1'b0}};
        end else begin
            base_s = pad_rd_s;
        end
        prod_ext_s = DW'(s1_prod_q);
        sum_wrap_s = base_s + prod_ext_s;
`ifdef PSUM_SAT_EN
        // Overflow only when both operands share a sign the result lost
        ovf_s = (base_s[DW-1] == prod_ext_s[DW-1]) &&
                (sum_wrap_s[DW-1] != base_s[DW-1]);
        if (ovf_s) begin
            if (base_s[DW-1]) begin
                sum_s = SUM_MIN;
            end else begin
                sum_s = SUM_MAX;
            end
        end else begin
            sum_s = sum_wrap_s;
        end
`else
        sum_s = sum_wrap_s;
`endif
    end

    // Pad write-back; an out-of-range address matches no entry, so it is
    // dropped here while the result path still carries the sum
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (i_clr) begin
                pad_d[i] = {DW{1'b0}};
            end else if (s1_valid_q && (s1_addr_q == AW'(i))) begin
                pad_d[i] = sum_s;
            end else begin
                pad_d[i] = pad_q[i];
            end
        end
    end

    // Result FIFO: push from stage 1, pop on Psum handshake, both allowed
    // on the same edge (count unchanged, pointers keep order)
    always_comb begin
        fifo_psum_d = fifo_psum_q;
        fifo_addr_d = fifo_addr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (i_clr) begin
            for (int j = 0; j < 2; j++) begin
                fifo_psum_d[j] = {DW{1'b0}};
                fifo_addr_d[j] = {AW{1'b0}};
            end
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            fifo_cnt_d = 2'd0;
        end else begin
            if (push_s) begin
                fifo_psum_d[wr_ptr_q] = sum_s;
                fifo_addr_d[wr_ptr_q] = s1_addr_q;
            end else begin
                fifo_psum_d = fifo_psum_q;
            end
            wr_ptr_d   = wr_ptr_q ^ push_s;
            rd_ptr_d   = rd_ptr_q ^ pop_s;
            fifo_cnt_d = fifo_cnt_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Stage-1 and FIFO registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= {AW{1'b0}};
            s1_prod_q  <= {PW{1'b0}};
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            for (int j = 0; j < 2; j++) begin
                fifo_psum_q[j] <= {DW{1'b0}};
                fifo_addr_q[j] <= {AW{1'b0}};
            end
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s1_prod_q   <= s1_prod_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            fifo_psum_q <= fifo_psum_d;
            fifo_addr_q <= fifo_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Pad register file; reset discards every partial sum
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pad_q[i] <= {DW{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pad_q[i] <= pad_d[i];
            end
        end
    end

`ifdef PSUM_SAT_EN
    // Sticky saturation flag, cleared only by i_clr or reset
    always_comb begin
        if (i_clr) begin
            sat_d = 1'b0;
        end else if (s1_valid_q && ovf_s) begin
            sat_d = 1'b1;
        end else begin
            sat_d = sat_q;
        end
    end

    // Saturation flag register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign o_sat = sat_q;
`endif

endmodule

// File: tb/tb_psum_accum_pad.sv
// Scoreboard bench for psum_accum_pad. Stimulus pushes expected results;
// a negedge monitor pops and compares on every Psum handshake.
module tb_psum_accum_pad;
    localparam int DEPTH = 12;
    localparam int PW    = 16;
    localparam int DW    = 20;
    localparam int AW    = 4;
`ifdef PSUM_SAT_EN
    localparam logic [DW-1:0] EXP_OVF = 20'h7FFFF;
`else
    localparam logic [DW-1:0] EXP_OVF = 20'h80000;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_clr;
    logic          Prod_rdy;
    logic          Prod_ack;
    logic [PW-1:0] i_prod;
    logic [AW-1:0] i_paddr;
    logic          i_first;
    logic          i_last;
    logic          Psum_rdy;
    logic          Psum_ack;
    logic [DW-1:0] o_psum;
    logic [AW-1:0] o_paddr;
    logic          o_busy;
`ifdef PSUM_SAT_EN
    logic          o_sat;
`endif

    int tests = 0;
    int fails = 0;
    logic [DW+AW-1:0] exp_q [$];

    psum_accum_pad #(.DEPTH(DEPTH), .PW(PW), .DW(DW)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (i_clr),
        .Prod_rdy (Prod_rdy),
        .Prod_ack (Prod_ack),
        .i_prod   (i_prod),
        .i_paddr  (i_paddr),
        .i_first  (i_first),
        .i_last   (i_last),
        .Psum_rdy (Psum_rdy),
        .Psum_ack (Psum_ack),
        .o_psum   (o_psum),
        .o_paddr  (o_paddr),
        .o_busy   (o_busy)
`ifdef PSUM_SAT_EN
        ,
        .o_sat    (o_sat)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one product; a closing product queues its expected result
    task automatic send(input logic [PW-1:0] p, input logic [AW-1:0] a,
                        input logic f, input logic l, input logic [DW-1:0] exp);
        int n;
        if (l) exp_q.push_back({exp, a});
        Prod_rdy = 1'b1;
        i_prod   = p;
        i_paddr  = a;
        i_first  = f;
        i_last   = l;
        n = 0;
        while (1) begin
            @(negedge i_clk);
            if (Prod_ack) break;
            n++;
            if (n >= 200) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: product 0x%0h addr %0d never accepted", p, a);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        Prod_rdy = 1'b0;
    endtask

    // Wait (bounded) for all expected results to be consumed
    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge i_clk);
            #1;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare the FIFO head on each result handshake
    always @(negedge i_clk) begin : mon
        logic [DW+AW-1:0] e;
        if (i_rst && !i_clr && Psum_rdy && Psum_ack) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got psum 0x%0h addr %0d, expected none", o_psum, o_paddr);
            end else begin
                e = exp_q.pop_front();
                chk("psum", 32'(o_psum), 32'(e[DW+AW-1:AW]));
                chk("paddr", 32'(o_paddr), 32'(e[AW-1:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst = 1'b0; i_clr = 1'b0; Prod_rdy = 1'b0; Psum_ack = 1'b0;
        i_prod = '0; i_paddr = '0; i_first = 1'b0; i_last = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_prod_ack", 32'(Prod_ack), 32'd0);
        chk("rst_psum_rdy", 32'(Psum_rdy), 32'd0);
        chk("rst_psum", 32'(o_psum), 32'd0);
        chk("rst_paddr", 32'(o_paddr), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("ack_after_reset", 32'(Prod_ack), 32'd1);
        Psum_ack = 1'b1;
        @(posedge i_clk);
        #1;

        // 3 + 4 + 5 at addr 2, result valid exactly one cycle
        send(16'd3, 4'd2, 1'b1, 1'b0, 20'd0);
        send(16'd4, 4'd2, 1'b0, 1'b0, 20'd0);
        send(16'd5, 4'd2, 1'b0, 1'b1, 20'd12);
        chk("lat_edge1_rdy", 32'(Psum_rdy), 32'd0);
        @(posedge i_clk); #1;
        chk("lat_edge2_rdy", 32'(Psum_rdy), 32'd1);
        @(posedge i_clk); #1;
        chk("lat_edge3_rdy", 32'(Psum_rdy), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);

        // Interleaved accumulations, then read pads back by adding 0
        send(16'd1,  4'd0, 1'b1, 1'b0, 20'd0);
        send(16'd10, 4'd1, 1'b1, 1'b0, 20'd0);
        send(16'd2,  4'd0, 1'b0, 1'b1, 20'd3);
        send(16'd20, 4'd1, 1'b0, 1'b1, 20'd30);
        send(16'd0,  4'd0, 1'b0, 1'b1, 20'd3);
        send(16'd0,  4'd1, 1'b0, 1'b1, 20'd30);
        drain();

        // Backpressure: third closing product waits for a pop
        Psum_ack = 1'b0;
        send(16'd100, 4'd3, 1'b1, 1'b1, 20'd100);
        send(16'd200, 4'd4, 1'b1, 1'b1, 20'd200);
        fork
            send(16'd300, 4'd5, 1'b1, 1'b1, 20'd300);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge i_clk);
                    chk("ack_dropped", 32'(Prod_ack), 32'd0);
                end
                chk("full_rdy", 32'(Psum_rdy), 32'd1);
                @(posedge i_clk); #1;
                Psum_ack = 1'b1;
            end
        join
        drain();

        // Wrap (or clamp) at the signed DW boundary: build 0x7FFFF, add 1
        send(16'h7FFF, 4'd6, 1'b1, 1'b0, 20'd0);
        for (int k = 0; k < 15; k++) send(16'h7FFF, 4'd6, 1'b0, 1'b0, 20'd0);
        send(16'h000F, 4'd6, 1'b0, 1'b0, 20'd0);
`ifdef PSUM_SAT_EN
        chk("sat_before", 32'(o_sat), 32'd0);
`endif
        send(16'h0001, 4'd6, 1'b0, 1'b1, EXP_OVF);
        @(posedge i_clk); #1;
`ifdef PSUM_SAT_EN
        chk("sat_after", 32'(o_sat), 32'd1);
`endif
        // Negative sign extension and out-of-range addresses
        send(16'hFFFB, 4'd7,  1'b1, 1'b0, 20'd0);
        send(16'h0003, 4'd7,  1'b0, 1'b1, 20'hFFFFE);
        send(16'h0009, 4'd14, 1'b1, 1'b0, 20'd0);
        send(16'h0005, 4'd14, 1'b0, 1'b1, 20'd5);
        send(16'h0007, 4'd13, 1'b1, 1'b1, 20'd7);
        drain();

        // Clear with stage 1 busy and one result queued
        Psum_ack = 1'b0;
        send(16'd1, 4'd0, 1'b1, 1'b1, 20'd1);
        send(16'd2, 4'd1, 1'b1, 1'b1, 20'd2);
        chk("pre_clr_busy", 32'(o_busy), 32'd1);
        chk("pre_clr_rdy", 32'(Psum_rdy), 32'd1);
        i_clr = 1'b1;
        exp_q.delete();
        @(posedge i_clk); #1;
        i_clr = 1'b0;
        chk("clr_rdy", 32'(Psum_rdy), 32'd0);
        chk("clr_busy", 32'(o_busy), 32'd0);
`ifdef PSUM_SAT_EN
        chk("clr_sat", 32'(o_sat), 32'd0);
`endif
        Psum_ack = 1'b1;
        for (int a = 0; a < DEPTH; a++) send(16'd0, AW'(a), 1'b0, 1'b1, 20'd0);
        send(16'd7, 4'd3, 1'b1, 1'b1, 20'd7);
        drain();

        // Reset mid-accumulation loses partial sums
        send(16'd5, 4'd4, 1'b1, 1'b0, 20'd0);
        send(16'd6, 4'd4, 1'b0, 1'b0, 20'd0);
        i_rst = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(Prod_ack), 32'd0);
        chk("mid_rst_rdy", 32'(Psum_rdy), 32'd0);
        chk("mid_rst_psum", 32'(o_psum), 32'd0);
        chk("mid_rst_paddr", 32'(o_paddr), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        send(16'd2, 4'd4, 1'b0, 1'b1, 20'd2);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/psum_accum_pad.md
PSUM_ACCUM_PAD -- requirements
Module: psum_accum_pad

Interface
REQ-001 Parameters SHALL be one per line:
- DEPTH, default 16: number of psum pad entries.
- PW, default 16: signed product width.
- DW, default 20: signed psum width; DW >= PW.
- AW, default $clog2(DEPTH): address width.

REQ-002 Ports SHALL be one per line:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-low.
- i_clr  in  1  synchronous clear pulse (PE instruction reset).
- Prod_rdy  in  1  product valid.
- Prod_ack  out  1  product accepted.
- i_prod  in  PW  signed product.
- i_paddr  in  AW  target pad entry.
- i_first  in  1  first product of an accumulation; overwrite, do not add.
- i_last  in  1  last product of an accumulation; emit result.
- Psum_rdy  out  1  result valid.
- Psum_ack  in  1  result consumed.
- o_psum  out  DW  result value.
- o_paddr  out  AW  result entry address.
- o_busy  out  1  stage or FIFO occupied.

Function
REQ-003 A transfer SHALL occur on any edge where rdy && ack; neither side SHALL hold a combinational path from the peer's signal to its own rdy or ack.
REQ-004 On a Prod transfer at edge t, the stage-1 register SHALL capture {addr, prod, first, last} and set s1_valid.
REQ-005 In the cycle after capture, the block SHALL compute sum = first ? sext(prod) : pad[addr] + sext(prod) and write sum to pad[addr] at edge t+1; the pad SHALL be a register file, so back-to-back products to the same address see the updated value with no stall.
REQ-006 If the stage-1 product has last=1, the block SHALL push {sum, addr} into a 2-entry output FIFO at the same edge t+1; Psum_rdy SHALL assert in cycle t+1 (latency 2 edges from product accept to result valid).
REQ-007 Prod_ack SHALL equal !i_clr && (fifo_cnt + (s1_valid && s1_last)) < 2, all from registered state only.
REQ-008 Psum_rdy SHALL equal fifo_cnt != 0; o_psum and o_paddr SHALL come from the FIFO head.
REQ-009 A FIFO push and a pop on the same edge SHALL leave fifo_cnt unchanged and preserve order; a push into a full FIFO SHALL be impossible by REQ-007.
REQ-010 Arithmetic without the configuration macro SHALL wrap modulo 2^DW in two's complement.
REQ-011 An i_paddr >= DEPTH SHALL be ignored for the pad write; the result SHALL still be emitted if last=1, with value sext(prod) when first=1 and 0 + sext(prod) otherwise.
REQ-012 o_busy SHALL equal s1_valid || fifo_cnt != 0.
REQ-013 i_clr SHALL have priority over all other activity and, at the next edge:
- zero all pad entries;
- clear s1_valid and fifo_cnt;
- drop any product or result in flight.
A Psum transfer in the clr cycle SHALL be discarded by the producer side.

Reset
REQ-014 While i_rst=0, the block SHALL asynchronously hold Prod_ack=0, Psum_rdy=0, o_psum=0, o_paddr=0, o_busy=0, all pad entries=0, s1_valid=0 and fifo_cnt=0.
REQ-015 After i_rst deasserts, Prod_ack SHALL be 1 in the first cycle.
REQ-016 Reset asserted mid-accumulation SHALL lose all partial sums.

Configuration
REQ-017 With PSUM_SAT_EN defined, sums SHALL saturate to signed DW min/max instead of wrapping, and a sticky output o_sat (1 bit) SHALL set on any saturation, cleared only by i_clr or reset.
REQ-018 Without PSUM_SAT_EN, o_sat SHALL not exist and arithmetic SHALL wrap per REQ-010.

Verification
REQ-019 Products 3(first), 4, 5(last) to addr 2 with Psum_ack=1 -> single result o_psum=12, o_paddr=2, Psum_rdy exactly 1 cycle, two edges after the last accept.
REQ-020 Interleaved products addr0 {1f, 2l} and addr1 {10f, 20l} -> results in order (0,3) then (1,30); pad[0]=3, pad[1]=30.
REQ-021 Psum_ack=0 with three last=1 products sent back-to-back -> Prod_ack drops after the second accept; the third is accepted only after a Psum pop; no loss and order kept.
REQ-022 DW=20: 0x7FFFF(first) + 1(last) -> 0x80000 without macro; with PSUM_SAT_EN -> 0x7FFFF and o_sat=1.
REQ-023 i_clr asserted while s1_valid=1 and FIFO holds 1 -> next cycle Psum_rdy=0, o_busy=0, pad all zero; a subsequent accumulation 7(first,last) -> result 7.
REQ-024 i_rst pulsed low mid-accumulation -> all outputs 0 immediately; after release, 2(last, not first) -> result 2.
